// File: rtl/load_queue_if.sv
// Handshake bundle between the load FU, data memory and the CDB for load_queue.
// slave = the queue itself, master = the surrounding pipeline/memory.
interface load_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) ();
  logic             squash;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_addr;
  logic [2:0]       in_mem_size;
  logic [TAG_W-1:0] in_tag;
  logic             mem_req_valid;
  logic [XLEN-1:0]  mem_req_addr;
  logic             mem_req_ready;
  logic             mem_resp_valid;
  logic [XLEN-1:0]  mem_resp_data;
  logic             cdb_valid;
  logic [XLEN-1:0]  cdb_value;
  logic [TAG_W-1:0] cdb_tag;
  logic             cdb_exc;
  logic             cdb_ack;

  modport slave (
    input  squash, in_valid, in_addr, in_mem_size, in_tag,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, cdb_ack,
    output in_ready, mem_req_valid, mem_req_addr, cdb_valid, cdb_value, cdb_tag, cdb_exc
  );

  modport master (
    output squash, in_valid, in_addr, in_mem_size, in_tag,
    output mem_req_ready, mem_resp_valid, mem_resp_data, cdb_ack,
    input  in_ready, mem_req_valid, mem_req_addr, cdb_valid, cdb_value, cdb_tag, cdb_exc
  );
endinterface

// File: rtl/load_queue.sv
// In-order load queue: one outstanding Dmem read at a time, byte/half/word extraction, CDB handoff.
// Optional misaligned-load trap enabled by defining LQ_MISALIGN_TRAP_EN.
module load_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input logic        clock,
  input logic        reset,
  load_queue_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrain} state_e;

  localparam int unsigned    PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0]  CntFull = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW:0]  CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  function automatic logic [XLEN-1:0] extract(input logic [2:0] sz, input logic [1:0] lane,
                                              input logic [XLEN-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lane, 3'b000} +: 8];
    h = d[{lane[1], 4'b0000} +: 16];
    case (sz)
      3'b000:  return {{(XLEN - 8){b[7]}}, b};
      3'b001:  return {{(XLEN - 16){h[15]}}, h};
      3'b100:  return {{(XLEN - 8){1'b0}}, b};
      3'b101:  return {{(XLEN - 16){1'b0}}, h};
      default: return d;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PtrW:0]    count_q, count_d;
  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [2:0]       size_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic             cdb_valid_q, cdb_valid_d;
  logic [XLEN-1:0]  cdb_value_q, cdb_value_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic             enq, pop;
  logic [XLEN-1:0]  head_addr;
  logic [2:0]       head_size;
  logic [TAG_W-1:0] head_tag;

  // Trap decisions for the entry that becomes head when leaving IDLE or after a pop.
  logic             idle_trap, next_trap;
  logic [TAG_W-1:0] idle_tag, next_tag;

  assign head_addr = addr_q[head_q];
  assign head_size = size_q[head_q];
  assign head_tag  = tag_q[head_q];

  assign bus.in_ready      = (count_q != CntFull) && (state_q != StDrain);
  assign enq               = bus.in_valid && bus.in_ready && !bus.squash;
  assign bus.mem_req_valid = (state_q == StReq);
  assign bus.mem_req_addr  = {head_addr[XLEN-1:2], 2'b00};
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_value     = cdb_value_q;
  assign bus.cdb_tag       = cdb_tag_q;

`ifdef LQ_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] sz, input logic [1:0] lo);
    case (sz)
      3'b001, 3'b101: return lo[0];
      3'b010:         return lo != 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  logic [PtrW-1:0] nxt_ptr;
  logic            cdb_exc_q, cdb_exc_d;

  assign nxt_ptr     = head_q + PtrOne;
  assign bus.cdb_exc = cdb_exc_q;

  // With an empty queue (or a single entry being popped) the candidate is the incoming load.
  always_comb begin
    if (count_q != '0) begin
      idle_trap = misaligned(head_size, head_addr[1:0]);
      idle_tag  = head_tag;
    end else begin
      idle_trap = misaligned(bus.in_mem_size, bus.in_addr[1:0]);
      idle_tag  = bus.in_tag;
    end
    if (count_q > CntOne) begin
      next_trap = misaligned(size_q[nxt_ptr], addr_q[nxt_ptr][1:0]);
      next_tag  = tag_q[nxt_ptr];
    end else begin
      next_trap = misaligned(bus.in_mem_size, bus.in_addr[1:0]);
      next_tag  = bus.in_tag;
    end
  end

  always_comb begin
    cdb_exc_d = cdb_exc_q;
    if (bus.squash) begin
      cdb_exc_d = 1'b0;
    end else if (state_q == StIdle && (count_q != '0 || enq)) begin
      cdb_exc_d = idle_trap;
    end else if (state_q == StWait && bus.mem_resp_valid) begin
      cdb_exc_d = 1'b0;
    end else if (state_q == StDone && bus.cdb_ack) begin
      cdb_exc_d = next_trap && ((count_q != CntOne) || enq);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cdb_exc_q <= 1'b0;
    else        cdb_exc_q <= cdb_exc_d;
  end
`else
  assign idle_trap   = 1'b0;
  assign next_trap   = 1'b0;
  assign idle_tag    = '0;
  assign next_tag    = '0;
  assign bus.cdb_exc = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    cdb_valid_d = cdb_valid_q;
    cdb_value_d = cdb_value_q;
    cdb_tag_d   = cdb_tag_q;
    pop         = 1'b0;

    if (bus.squash) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      cdb_valid_d = 1'b0;
      // Any accepted-but-unanswered request must have its response swallowed.
      unique case (state_q)
        StWait:  state_d = bus.mem_resp_valid ? StIdle : StDrain;
        StReq:   state_d = bus.mem_req_ready ? StDrain : StIdle;
        StDrain: state_d = bus.mem_resp_valid ? StIdle : StDrain;
        default: state_d = StIdle;
      endcase
    end else begin
      if (enq) tail_d = tail_q + PtrOne;

      unique case (state_q)
        StIdle: begin
          if (count_q != '0 || enq) begin
            if (idle_trap) begin
              state_d     = StDone;
              cdb_valid_d = 1'b1;
              cdb_value_d = '0;
              cdb_tag_d   = idle_tag;
            end else begin
              state_d = StReq;
            end
          end
        end
        StReq: if (bus.mem_req_ready) state_d = StWait;
        StWait: begin
          if (bus.mem_resp_valid) begin
            state_d     = StDone;
            cdb_valid_d = 1'b1;
            cdb_value_d = extract(head_size, head_addr[1:0], bus.mem_resp_data);
            cdb_tag_d   = head_tag;
          end
        end
        StDone: begin
          if (bus.cdb_ack) begin
            pop         = 1'b1;
            head_d      = head_q + PtrOne;
            cdb_valid_d = 1'b0;
            if ((count_q != CntOne) || enq) begin
              if (next_trap) begin
                state_d     = StDone;
                cdb_valid_d = 1'b1;
                cdb_value_d = '0;
                cdb_tag_d   = next_tag;
              end else begin
                state_d = StReq;
              end
            end else begin
              state_d = StIdle;
            end
          end
        end
        StDrain: if (bus.mem_resp_valid) state_d = StIdle;
        default: state_d = StIdle;
      endcase

      if (enq && !pop)      count_d = count_q + CntOne;
      else if (!enq && pop) count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      cdb_valid_q <= 1'b0;
      cdb_value_q <= '0;
      cdb_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_value_q <= cdb_value_d;
      cdb_tag_q   <= cdb_tag_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        size_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (enq) begin
      addr_q[tail_q] <= bus.in_addr;
      size_q[tail_q] <= bus.in_mem_size;
      tag_q[tail_q]  <= bus.in_tag;
    end
  end

endmodule

// File: doc/load_queue.md
Name: load_queue

Overview:
- Sits directly downstream of the load FU's address path.
- Accepts address-computed loads (address, funct3 size, ROB tag) into an in-order FIFO and issues them to data memory one at a time.
- Extracts and sign- or zero-extends the returned byte, half or word, then presents the result to the CDB/complete stage under a valid/ack handshake.
- A branch squash flushes all pending loads.

Parameters:
- DEPTH, 4, number of queued loads; power of two, at least 2.
- XLEN, 32, data and address width.
- TAG_W, 5, ROB tag width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- squash  in  1  synchronous flush of all queued and in-flight loads
- in_valid  in  1  load FU presents a load
- in_ready  out  1  queue can accept; equals (count < DEPTH) && state != DRAIN
- in_addr  in  XLEN  effective address (rs1 + I-imm)
- in_mem_size  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- in_tag  in  TAG_W  ROB tag
- mem_req_valid  out  1  read request to Dmem
- mem_req_addr  out  XLEN  head address with bits [1:0] forced to 0
- mem_req_ready  in  1  Dmem accepts request this cycle
- mem_resp_valid  in  1  read data returned; one response per accepted request
- mem_resp_data  in  XLEN  aligned word
- cdb_valid  out  1  completed load available
- cdb_value  out  XLEN  extended load result
- cdb_tag  out  TAG_W  ROB tag of the completed load
- cdb_exc  out  1  misaligned-load flag (see Optional Feature)
- cdb_ack  in  1  consumer takes the result

Behaviour:
- Reset (reset==0, asynchronous): count=0, head=tail=0, state=IDLE; cdb_valid, cdb_value, cdb_tag, cdb_exc and mem_req_valid all 0; in_ready=1 once reset is released.
- FIFO:
  - Enqueue when in_valid && in_ready.
  - Head pops only on the DONE && cdb_ack cycle.
  - Pointers wrap modulo DEPTH.
  - Simultaneous enqueue and pop when full is illegal: in_ready is already low at full.
  - Simultaneous enqueue and pop at any other count leaves count unchanged.
- State machine, transitions on clock edges:
  - IDLE: if count>0, go to REQ.
  - REQ: mem_req_valid=1. On mem_req_ready, go to WAIT. Address and size come from the head entry and are held stable until accepted.
  - WAIT: on mem_resp_valid, register cdb_value, cdb_tag and cdb_exc=0, set cdb_valid=1, go to DONE.
  - DONE: cdb_valid held with its value stable until cdb_ack. On ack, pop the head, clear cdb_valid, and go to REQ if count after pop > 0, else IDLE.
- Latency:
  - Enqueue into an empty queue at cycle N gives mem_req_valid at N+1.
  - Response at cycle K gives cdb_valid at K+1.
  - A back-to-back queued load is requested the cycle after the ack.
- Extraction, with lane = addr[1:0]:
  - LB and LBU select byte data[8*lane+7 : 8*lane].
  - LH and LHU select half data[16*addr[1]+15 : 16*addr[1]].
  - LW takes the full word.
  - LB and LH sign-extend to XLEN; LBU and LHU zero-extend.
  - Unlisted funct3 values behave as LW.
- Squash (synchronous, priority over all other events in the same cycle):
  - count, head and tail cleared; cdb_valid cleared.
  - Same-cycle enqueue discarded.
  - From WAIT, or from REQ with mem_req_ready high in the squash cycle, go to DRAIN. Otherwise go to IDLE.
  - DRAIN: mem_req_valid=0, in_ready=0. Wait for mem_resp_valid, discard the data, go to IDLE.
- A reset asserted mid-operation clears everything regardless of state; no drain is performed.

Optional Feature:
- Macro: LQ_MISALIGN_TRAP_EN.
- Defined:
  - A head entry that is misaligned (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0) skips REQ/WAIT.
  - It goes from IDLE or after-pop directly to DONE with cdb_exc=1, cdb_value=0 and cdb_tag=head tag.
  - No memory request is made.
- Not defined: cdb_exc is tied 0 and misaligned addresses are handled by the normal lane selection (low bits truncated as above).

Test Plan:
- Reset, then LW addr 0x100 tag 3; mem_req_ready at the next cycle; resp data 0xDEADBEEF two cycles later -> mem_req_addr=0x100; cdb_valid with cdb_value=0xDEADBEEF, cdb_tag=3 one cycle after the response; held until cdb_ack.
- LB addr 0x203 and LBU addr 0x203, data 0x80FF1234 -> cdb_value 0xFFFFFF80, then 0x00000080; mem_req_addr=0x200 both times.
- LH addr 0x302, data 0x8001_7FFF -> 0xFFFF8001; LHU at the same address -> 0x00008001.
- Enqueue 4 loads with no mem_req_ready -> in_ready=0 after the 4th; a 5th in_valid is not accepted. Complete all four -> tags emerge in order; in_ready returns 1 after the first ack.
- Squash while in WAIT with 2 entries queued -> next cycle count=0, in_ready=0; late response 0x12345678 produces no cdb_valid; then IDLE and in_ready=1.
- With LQ_MISALIGN_TRAP_EN: LW addr 0x101 tag 7 -> no mem_req_valid; cdb_valid with cdb_exc=1, cdb_tag=7, cdb_value=0. Without the macro: request to 0x100, result = full word.
